// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared Common Data Bus. Each functional unit
// raises a request carrying its result tag/value. One eligible requester is
// granted per cycle, starting the search at the rotating pointer. The winner's
// tag/value is registered and broadcast on the next cycle, together with a
// one-hot done pulse back to the source unit. Tag 0 is the invalid tag: it is
// never granted and is what the bus carries while idle.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [N_REQ-1:0]          done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic              grant_any;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  win_onehot;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // Eligible requesters: only requests carrying a valid (non-zero) tag count.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && (req_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  // Round-robin search starting at ptr; first eligible index wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Grant decode and winner payload mux; flush suppresses any grant.
  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
    grant_any       = found && !flush;
    gnt             = grant_any ? win_onehot : '0;
    win_tag         = req_tag[int'(win)*TAG_W +: TAG_W];
    win_data        = req_data[int'(win)*DATA_W +: DATA_W];
  end

  // Broadcast register: one-cycle pulse of the winner, idle (tag 0) otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      done      <= '0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= win_tag;
      cdb_data  <= win_data;
      done      <= win_onehot;
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      done      <= '0;
    end
  end

  // Pointer moves just past the winner on a grant; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (int'(win) == N_REQ - 1) begin
        ptr <= '0;
      end else begin
        ptr <= win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with N_REQ=4, DATA_W=32, TAG_W=4.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req;
  logic [15:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  gnt;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  done;

  int checks;
  int failures;

  cdb_arbiter #(.N_REQ(4), .DATA_W(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req       (req),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .gnt       (gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [3:0] t, input logic [31:0] d);
    req_tag[i*4 +: 4]   = t;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd0);
    chk({tag, "_tag"},   64'(cdb_tag),   64'd0);
    chk({tag, "_data"},  64'(cdb_data),  64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
  endtask

  task automatic chk_bcast(input string tag, input logic [3:0] t, input logic [31:0] d,
                           input logic [3:0] dn);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_tag"},   64'(cdb_tag),   64'(t));
    chk({tag, "_data"},  64'(cdb_data),  64'(d));
    chk({tag, "_done"},  64'(done),      64'(dn));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    req      = 4'b1111;
    req_tag  = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) set_fu(i, 4'(i + 1), 32'hA000_0000 + 32'(i));

    // Reset with every unit requesting.
    tick();
    tick();
    chk_idle("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_ptr0_gnt", 64'(gnt), 64'b0001);

    // All four requesting and held: strict rotation, wrap back to FU0.
    tick();
    chk_bcast("all0", 4'd1, 32'hA000_0000, 4'b0001);
    chk("all_gnt1", 64'(gnt), 64'b0010);
    tick();
    chk_bcast("all1", 4'd2, 32'hA000_0001, 4'b0010);
    chk("all_gnt2", 64'(gnt), 64'b0100);
    tick();
    chk_bcast("all2", 4'd3, 32'hA000_0002, 4'b0100);
    chk("all_gnt3", 64'(gnt), 64'b1000);
    tick();
    chk_bcast("all3", 4'd4, 32'hA000_0003, 4'b1000);
    chk("all_wrap_gnt", 64'(gnt), 64'b0001);
    req = 4'b0000;
    #1;
    chk("none_gnt", 64'(gnt), 64'b0000);
    tick();
    chk_idle("none");

    // Single requester, ptr=0; stays granted back-to-back with ptr=3.
    req = 4'b0100;
    set_fu(2, 4'd5, 32'hDEAD_BEEF);
    #1;
    chk("single_gnt", 64'(gnt), 64'b0100);
    tick();
    chk_bcast("single", 4'd5, 32'hDEAD_BEEF, 4'b0100);
    chk("single_again_gnt", 64'(gnt), 64'b0100);
    tick();
    chk_bcast("single_b2b", 4'd5, 32'hDEAD_BEEF, 4'b0100);
    req = 4'b0000;
    tick();

    // Tag 0 is ineligible: ptr=3, FU0 (tag 0) skipped, FU1 (tag 3) wins.
    req = 4'b0011;
    set_fu(0, 4'd0, 32'h1111_0000);
    set_fu(1, 4'd3, 32'h2222_0001);
    #1;
    chk("inval_gnt", 64'(gnt), 64'b0010);
    tick();
    chk_bcast("inval", 4'd3, 32'h2222_0001, 4'b0010);
    chk("inval_again_gnt", 64'(gnt), 64'b0010);
    req = 4'b0000;
    tick();
    tick();

    // Fairness: move ptr to 0 via FU3, then FU0 continuous + FU2 once.
    req = 4'b1000;
    set_fu(3, 4'd7, 32'h7777_0003);
    #1;
    chk("fair_setup_gnt", 64'(gnt), 64'b1000);
    tick();
    chk_bcast("fair_setup", 4'd7, 32'h7777_0003, 4'b1000);
    req = 4'b0101;
    set_fu(0, 4'd1, 32'h0000_00F0);
    set_fu(2, 4'd2, 32'h0000_00F2);
    #1;
    chk("fair_gnt0", 64'(gnt), 64'b0001);
    tick();
    chk_bcast("fair0", 4'd1, 32'h0000_00F0, 4'b0001);
    chk("fair_gnt2", 64'(gnt), 64'b0100);
    tick();
    chk_bcast("fair2", 4'd2, 32'h0000_00F2, 4'b0100);
    req = 4'b1001;
    #1;
    chk("fair_ptr3_gnt", 64'(gnt), 64'b1000);
    tick();
    chk_bcast("fair3", 4'd7, 32'h7777_0003, 4'b1000);
    req = 4'b0000;
    tick();

    // Flush: in-flight broadcast completes, no grant, ptr held at 2.
    req = 4'b0010;
    set_fu(1, 4'd6, 32'h6666_0001);
    #1;
    chk("flush_pre_gnt", 64'(gnt), 64'b0010);
    tick();
    req   = 4'b1001;
    flush = 1'b1;
    #1;
    chk("flush_gnt", 64'(gnt), 64'b0000);
    chk_bcast("flush_inflight", 4'd6, 32'h6666_0001, 4'b0010);
    tick();
    chk_idle("flush_after");
    flush = 1'b0;
    #1;
    chk("flush_ptr_held_gnt", 64'(gnt), 64'b1000);
    tick();
    chk_bcast("flush_resume", 4'd7, 32'h7777_0003, 4'b1000);

    // Reset in the middle of a broadcast: idle at once, ptr back to 0.
    req = 4'b0100;
    set_fu(2, 4'd5, 32'h5555_0002);
    tick();
    chk_bcast("midrst_pre", 4'd5, 32'h5555_0002, 4'b0100);
    req = 4'b1111;
    set_fu(1, 4'd2, 32'h2222_0001);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    rst_n = 1'b1;
    #1;
    chk("midrst_ptr0_gnt", 64'(gnt), 64'b0001);
    tick();
    chk_bcast("midrst_post", 4'd1, 32'h0000_00F0, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
